// File: rtl/ysyx_22050598_muldiv.sv
// Iterative radix-2 RV64M multiply/divide unit: shift-add multiply, restoring divide.
// One bit per cycle; divide-by-zero and signed overflow resolve at accept.
module ysyx_22050598_muldiv #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            muldiv_valid,
  input  logic            flush,
  input  logic            exu_is_mul,
  input  logic            exu_is_div,
  input  logic            exu_is_rem,
  input  logic            mul_hi,
  input  logic            src1_signed,
  input  logic            src2_signed,
  input  logic            is_word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            muldiv_ready,
  output logic            muldivout_valid,
  output logic [XLEN-1:0] muldiv_result
);
  localparam int HW = XLEN / 2;
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [XLEN-1:0]   opb_q, opb_d, res_q, res_d;
  logic              fast_q, fast_d, word_q, word_d, hi_q, hi_d;
  logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic              is_mul_q, is_mul_d, is_rem_q, is_rem_d;

  // Operand preparation: word ops extend the low half per signedness.
  logic [XLEN-1:0] op_a, op_b, mag_a, mag_b, min_v, fast_raw, fast_res;
  logic            neg_a, neg_b, div_zero, div_ovf, accept;

  assign op_a  = is_word ? {{HW{src1_signed & src1[HW-1]}}, src1[HW-1:0]} : src1;
  assign op_b  = is_word ? {{HW{src2_signed & src2[HW-1]}}, src2[HW-1:0]} : src2;
  assign neg_a = src1_signed & op_a[XLEN-1];
  assign neg_b = src2_signed & op_b[XLEN-1];
  assign mag_a = neg_a ? -op_a : op_a;
  assign mag_b = neg_b ? -op_b : op_b;
  assign min_v = is_word ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};

  assign div_zero = (op_b == '0);
  assign div_ovf  = src1_signed & src2_signed & (op_a == min_v) & (&op_b);
  assign fast_raw = exu_is_rem ? (div_zero ? op_a : '0) : (div_zero ? '1 : op_a);
  assign fast_res = is_word ? {{HW{fast_raw[HW-1]}}, fast_raw[HW-1:0]} : fast_raw;
  assign accept   = muldiv_valid & (state_q == IDLE) & ~flush;

  // Datapath steps
  logic [XLEN:0]     div_trial;
  logic              div_ge;
  logic [CW-1:0]     last_cnt;

  assign div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_ge    = (div_trial >= {1'b0, opb_q});
  assign last_cnt  = word_q ? CW'(HW - 1) : CW'(XLEN - 1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    opb_d    = opb_q;
    res_d    = res_q;
    fast_d   = fast_q;
    word_d   = word_q;
    hi_d     = hi_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    is_mul_d = is_mul_q;
    is_rem_d = is_rem_q;
    case (state_q)
      IDLE: if (accept) begin
        word_d   = is_word;
        hi_d     = mul_hi;
        neg_a_d  = neg_a;
        neg_b_d  = neg_b;
        is_mul_d = exu_is_mul;
        is_rem_d = exu_is_rem & ~exu_is_mul;
        opb_d    = mag_b;
        cnt_d    = '0;
        fast_d   = 1'b0;
        res_d    = fast_res;
        if (exu_is_mul) begin
          acc_d   = '0;
          mcand_d = {{XLEN{1'b0}}, mag_a};
          state_d = MUL;
        end else begin
          // Word dividends sit in the top half so 32 steps consume them.
          acc_d = {{XLEN{1'b0}}, is_word ? {mag_a[HW-1:0], {HW{1'b0}}} : mag_a};
          if (div_zero | div_ovf) begin
            fast_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = DIV;
          end
        end
      end
      MUL: begin
        if (opb_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = {mcand_q[2*XLEN-2:0], 1'b0};
        opb_d   = {1'b0, opb_q[XLEN-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == last_cnt) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DIV: begin
        acc_d = {(div_ge ? div_trial[XLEN-1:0] - opb_q : div_trial[XLEN-1:0]),
                 acc_q[XLEN-2:0], div_ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == last_cnt) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      fast_q   <= 1'b0;
      word_q   <= 1'b0;
      hi_q     <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      is_mul_q <= 1'b0;
      is_rem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      fast_q   <= fast_d;
      word_q   <= word_d;
      hi_q     <= hi_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      is_mul_q <= is_mul_d;
      is_rem_q <= is_rem_d;
    end
  end

  // Sign fix-up and word sign-extension of the final value
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, raw;

  assign prod_s = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
  assign quo_s  = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_s  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    if (fast_q)        raw = res_q;
    else if (is_mul_q) raw = hi_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    else if (is_rem_q) raw = rem_s;
    else               raw = quo_s;
  end

  assign muldiv_ready    = (state_q == IDLE);
  assign muldivout_valid = (state_q == DONE) & ~flush;
  assign muldiv_result   = (state_q != DONE) ? '0 :
                           word_q ? {{HW{raw[HW-1]}}, raw[HW-1:0]} : raw;
endmodule

// File: tb/tb_ysyx_22050598_muldiv.sv
// Directed bench for the iterative mul/div unit: results, latency, flush, reset.
module tb_ysyx_22050598_muldiv;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        muldiv_valid = 1'b0, flush = 1'b0;
  logic        exu_is_mul = 1'b0, exu_is_div = 1'b0, exu_is_rem = 1'b0;
  logic        mul_hi = 1'b0, src1_signed = 1'b0, src2_signed = 1'b0, is_word = 1'b0;
  logic [63:0] src1 = '0, src2 = '0;
  logic        muldiv_ready, muldivout_valid;
  logic [63:0] muldiv_result;
  int          checks = 0;
  int          failures = 0;

  ysyx_22050598_muldiv #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .muldiv_valid(muldiv_valid), .flush(flush),
    .exu_is_mul(exu_is_mul), .exu_is_div(exu_is_div), .exu_is_rem(exu_is_rem),
    .mul_hi(mul_hi), .src1_signed(src1_signed), .src2_signed(src2_signed),
    .is_word(is_word), .src1(src1), .src2(src2), .muldiv_ready(muldiv_ready),
    .muldivout_valid(muldivout_valid), .muldiv_result(muldiv_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // op: 0=mul 1=div 2=rem; drives inputs at negedge, accept on the next posedge
  task automatic issue(input int op, input logic hi, input logic s1s, input logic s2s,
                       input logic w, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    exu_is_mul = (op == 0); exu_is_div = (op == 1); exu_is_rem = (op == 2);
    mul_hi = hi; src1_signed = s1s; src2_signed = s2s; is_word = w;
    src1 = a; src2 = b; muldiv_valid = 1'b1;
    @(posedge clk);
    #1 muldiv_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input int op, input logic hi, input logic s1s,
                        input logic s2s, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
    int          lat;
    logic [63:0] got;
    @(negedge clk);
    chk({tag, "_ready_before"}, {63'b0, muldiv_ready}, 64'd1);
    issue(op, hi, s1s, s2s, w, a, b);
    lat = -1;
    got = 'x;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (muldivout_valid) begin
        lat = k;
        got = muldiv_result;
        break;
      end
      if (k == 1) begin
        chk({tag, "_busy_ready"}, {63'b0, muldiv_ready}, 64'd0);
        muldiv_valid = 1'b1;  // must be ignored while busy
      end
      if (k == 2) muldiv_valid = 1'b0;
    end
    muldiv_valid = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_result"}, got, exp);
    @(negedge clk);
    chk({tag, "_one_strobe"}, {62'b0, muldivout_valid, muldiv_ready}, 64'd1);
  endtask

  initial begin
    int strobes;
    repeat (2) @(negedge clk);
    chk("reset_ready", {63'b0, muldiv_ready}, 64'd1);
    chk("reset_valid", {63'b0, muldivout_valid}, 64'd0);
    chk("reset_result", muldiv_result, 64'd0);
    rst = 1'b0;

    run_op("mul_7x-3", 0, 0, 1, 1, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    run_op("mulhu_max", 0, 1, 0, 0, 0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("mulhsu_-1x2", 0, 1, 1, 0, 0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("div_-7/2", 1, 0, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("rem_-7/2", 2, 0, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("divw_ovf", 1, 0, 1, 1, 1, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("divu_by0", 1, 0, 0, 0, 0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("rem_5/0", 2, 0, 1, 1, 0, 64'd5, 64'd0, 64'd5, 1);
    run_op("remuw", 2, 0, 0, 0, 1, 64'h1_0000_0009, 64'd4, 64'd1, 33);
    run_op("div_ovf64", 1, 0, 1, 1, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    run_op("mulw", 0, 0, 1, 1, 1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    run_op("divu_100/7", 1, 0, 0, 0, 0, 64'd100, 64'd7, 64'd14, 65);
    run_op("divw_-20/3", 1, 0, 1, 1, 1, 64'hDEAD_0000_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 33);
    run_op("remw_-20/3", 2, 0, 1, 1, 1, 64'h0000_0000_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 33);

    // Flush during a divide: no strobe, ready again the cycle after
    issue(1, 0, 0, 0, 0, 64'd1000, 64'd3);
    strobes = 0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (muldivout_valid) strobes++;
      if (k == 10) flush = 1'b1;
      if (k == 11) begin
        flush = 1'b0;
        chk("flush_ready", {63'b0, muldiv_ready}, 64'd1);
      end
    end
    chk("flush_no_strobe", 64'(strobes), 64'd0);
    run_op("mul_after_flush", 0, 0, 0, 0, 0, 64'd3, 64'd4, 64'd12, 65);

    // Flush in the accept cycle blocks acceptance
    @(negedge clk);
    flush = 1'b1;
    issue(0, 0, 0, 0, 0, 64'd5, 64'd5);
    flush = 1'b0;
    @(negedge clk);
    chk("flush_blocks_accept", {63'b0, muldiv_ready}, 64'd1);

    // Reset in the middle of a multiply
    issue(0, 0, 0, 0, 0, 64'd9, 64'd9);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ready", {63'b0, muldiv_ready}, 64'd1);
    chk("midrst_valid", {63'b0, muldivout_valid}, 64'd0);
    chk("midrst_result", muldiv_result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    strobes = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (muldivout_valid) strobes++;
    end
    chk("midrst_no_strobe", 64'(strobes), 64'd0);
    run_op("mul_after_rst", 0, 0, 0, 0, 0, 64'd6, 64'd7, 64'd42, 65);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
